// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, timing-total helper and the flag bundle carried down the delay pipe.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned ADDR_W_DEF   = 19;
  localparam int unsigned PIXEL_W      = 24;

  function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef struct packed {
    logic h_draw;
    logic v_draw;
    logic hsync;
    logic vsync;
    logic frame_start;
  } vga_flags_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters with raw (undelayed) draw, sync and frame-start flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output vga_flags_t flags_c_o,
  output logic       frame_end_c_o
);

  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HCW     = $clog2(H_TOTAL);
  localparam int unsigned VCW     = $clog2(V_TOTAL);

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;
  logic           h_last, v_last, h_in_sync, v_in_sync;

  assign h_last        = (h_cnt_q == HCW'(H_TOTAL - 1));
  assign v_last        = (v_cnt_q == VCW'(V_TOTAL - 1));
  assign frame_end_c_o = h_last & v_last;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en_i) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + VCW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_in_sync = (h_cnt_q >= HCW'(H_ACTIVE + H_FP)) && (h_cnt_q < HCW'(H_ACTIVE + H_FP + H_SYNC));
  assign v_in_sync = (v_cnt_q >= VCW'(V_ACTIVE + V_FP)) && (v_cnt_q < VCW'(V_ACTIVE + V_FP + V_SYNC));

  always_comb begin
    flags_c_o             = '0;
    flags_c_o.h_draw      = (h_cnt_q < HCW'(H_ACTIVE));
    flags_c_o.v_draw      = (v_cnt_q < VCW'(V_ACTIVE));
    flags_c_o.hsync       = h_in_sync ? SYNC_POL : ~SYNC_POL;
    flags_c_o.vsync       = v_in_sync ? SYNC_POL : ~SYNC_POL;
    flags_c_o.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/vga_img_sched.sv
// VGA scan-out memory scheduler: per-pixel read issue, latency-matched strobes, loader write arbitration.
module vga_img_sched
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = PIXEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              HDraw,
  output logic              VDraw,
  output logic              hsync,
  output logic              vsync,
  output logic [DATA_W-1:0] pixel,
  output logic              frame_start
);

  localparam vga_flags_t FLAGS_RST = vga_flags_t'({2'b00, ~SYNC_POL, ~SYNC_POL, 1'b0});

  vga_flags_t        raw_flags;
  logic              frame_end;
  logic              rd_active;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  vga_flags_t        pipe_q [RD_LAT];
  vga_flags_t        pipe_d [RD_LAT];
  vga_flags_t        out_flags;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .flags_c_o     (raw_flags),
    .frame_end_c_o (frame_end)
  );

  // Reads are suppressed while reset is held so the port is quiet during reset.
  assign rd_active = en & ~rst & raw_flags.h_draw & raw_flags.v_draw;

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (en) begin
      if (frame_end) begin
        rd_addr_d = '0;
      end else if (rd_active) begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    pipe_d = pipe_q;
    if (en) begin
      pipe_d[0] = raw_flags;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= FLAGS_RST;
      end
    end else begin
      rd_addr_q <= rd_addr_d;
      pipe_q    <= pipe_d;
    end
  end

  // Scan-out reads own the port; the loader only gets blanking cycles.
  always_comb begin
    mem_rd    = rd_active;
    wr_gnt    = wr_req & ~rd_active;
    mem_we    = wr_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_active) begin
      mem_addr = rd_addr_q;
    end else if (wr_gnt) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  assign out_flags   = pipe_q[RD_LAT-1];
  assign HDraw       = out_flags.h_draw;
  assign VDraw       = out_flags.v_draw;
  assign hsync       = out_flags.hsync;
  assign vsync       = out_flags.vsync;
  assign frame_start = out_flags.frame_start;
  assign pixel       = (out_flags.h_draw & out_flags.v_draw) ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_img_sched.sv
// Bench for vga_img_sched on a 14x7 timing: reference model with pixel scoreboard plus a line-0 vector table.
module tb_vga_img_sched;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int AW = 19, DW = 24;

  logic          clk = 1'b0;
  logic          rst, en, wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_we, wr_gnt;
  logic [DW-1:0] mem_wdata, mem_rdata, pixel;
  logic          HDraw, VDraw, hsync, vsync, frame_start;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  vga_img_sched #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .RD_LAT (1), .ADDR_W (AW), .DATA_W (DW)
  ) dut (
    .clk (clk), .rst (rst), .en (en),
    .mem_addr (mem_addr), .mem_rd (mem_rd), .mem_we (mem_we), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_gnt (wr_gnt),
    .HDraw (HDraw), .VDraw (VDraw), .hsync (hsync), .vsync (vsync),
    .pixel (pixel), .frame_start (frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {5'h15, a};
  endfunction

  // One-clock-latency memory
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_f(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state: count of the current cycle and the delayed flags
  int m_h = 0, m_v = 0, m_addr = 0;
  logic m_hd = 0, m_vd = 0, m_hs = 1, m_vs = 1, m_fs = 0, m_rdp = 0;
  logic [DW-1:0] m_pix = '0;
  logic [DW-1:0] sb[$];

  always @(negedge clk) begin
    logic e_rd, e_gnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_pix;
    if (rst) begin
      m_h = 0; m_v = 0; m_addr = 0;
      m_hd = 0; m_vd = 0; m_hs = 1; m_vs = 1; m_fs = 0; m_rdp = 0;
      sb.delete();
    end
    e_rd   = en && !rst && (m_h < HA) && (m_v < VA);
    e_gnt  = wr_req && !e_rd;
    e_addr = e_rd ? AW'(m_addr) : (e_gnt ? wr_addr : '0);
    e_wd   = e_gnt ? wr_data : '0;
    if (m_rdp) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
      else m_pix = sb.pop_front();
    end
    e_pix = (m_hd && m_vd) ? m_pix : '0;
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    chk("mem_we", 32'(mem_we), 32'(e_gnt));
    chk("wr_gnt", 32'(wr_gnt), 32'(e_gnt));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("HDraw", 32'(HDraw), 32'(m_hd));
    chk("VDraw", 32'(VDraw), 32'(m_vd));
    chk("hsync", 32'(hsync), 32'(m_hs));
    chk("vsync", 32'(vsync), 32'(m_vs));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("pixel", 32'(pixel), 32'(e_pix));
    if (e_rd) sb.push_back(mem_f(AW'(m_addr)));
    if (!rst && en) begin
      m_hd = (m_h < HA);
      m_vd = (m_v < VA);
      m_hs = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
      m_vs = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
      m_fs = (m_h == 0) && (m_v == 0);
      if (m_h == HT - 1 && m_v == VT - 1) m_addr = 0;
      else if (e_rd) m_addr++;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
    m_rdp = e_rd;
  end

  typedef struct {
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          e_rd;
    logic [AW-1:0] e_addr;
    logic          e_gnt;
    logic [DW-1:0] e_wdata;
    logic          e_hd;
    logic          e_hs;
  } vec_t;

  vec_t tbl [HT];

  initial begin
    int t0, t1;
    logic found;
    // Line 0 after reset release with the loader requesting every cycle
    for (int k = 0; k < HT; k++) begin
      tbl[k].wr_req  = 1'b1;
      tbl[k].wr_addr = AW'(32'h40000 + k);
      tbl[k].wr_data = DW'(32'hC00000 + k);
      tbl[k].e_rd    = (k < HA);
      tbl[k].e_gnt   = (k >= HA);
      tbl[k].e_addr  = (k < HA) ? AW'(k) : tbl[k].wr_addr;
      tbl[k].e_wdata = (k < HA) ? '0 : tbl[k].wr_data;
      tbl[k].e_hd    = (k >= 1) && (k <= HA);
      tbl[k].e_hs    = !((k - 1 >= HA + HF) && (k - 1 < HA + HF + HS));
    end

    rst = 1'b0; en = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    #1 rst = 1'b1; en = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_hsync", 32'(hsync), 32'd1);
      chk("rst_vsync", 32'(vsync), 32'd1);
      chk("rst_pixel", 32'(pixel), 32'd0);
    end

    for (int k = 0; k < HT; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b1;
      wr_req = tbl[k].wr_req; wr_addr = tbl[k].wr_addr; wr_data = tbl[k].wr_data;
      @(negedge clk); #1;
      chk("tbl_mem_rd", 32'(mem_rd), 32'(tbl[k].e_rd));
      chk("tbl_mem_addr", 32'(mem_addr), 32'(tbl[k].e_addr));
      chk("tbl_wr_gnt", 32'(wr_gnt), 32'(tbl[k].e_gnt));
      chk("tbl_mem_wdata", 32'(mem_wdata), 32'(tbl[k].e_wdata));
      chk("tbl_HDraw", 32'(HDraw), 32'(tbl[k].e_hd));
      chk("tbl_hsync", 32'(hsync), 32'(tbl[k].e_hs));
    end
    @(posedge clk); #1;
    wr_req = 1'b0;

    // Frame-start period
    found = 1'b0; t0 = 0; t1 = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (frame_start) begin found = 1'b1; t0 = cyc; end
    end
    chk("wait_fs0", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (frame_start) begin found = 1'b1; t1 = cyc; end
    end
    chk("wait_fs1", 32'(found), 32'd1);
    chk("fs_period", 32'(t1 - t0), 32'(HT * VT));

    // Freeze at h=4 of line 0 for 5 clocks
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (m_h == 4 && m_v == 0) found = 1'b1;
    end
    chk("wait_h4", 32'(found), 32'd1);
    en = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      chk("freeze_rd", 32'(mem_rd), 32'd0);
      @(posedge clk); #1;
    end
    en = 1'b1;
    @(negedge clk); #1;
    chk("resume_rd", 32'(mem_rd), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'd4);

    // Reset mid-frame at h=5, v=2
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (m_h == 5 && m_v == 2) found = 1'b1;
    end
    chk("wait_h5v2", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_rd", 32'(mem_rd), 32'd0);
    chk("midrst_HDraw", 32'(HDraw), 32'd0);
    chk("midrst_hsync", 32'(hsync), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_rd", 32'(mem_rd), 32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
